wb_ddr_arbiter: RTL and testbench

WB_DDR_ARBITER -- requirements
Module: wb_ddr_arbiter

---
 rtl/wb_ddr_arbiter_pkg.sv | 42 ++++
 rtl/wb_rr_picker.sv | 40 ++++
 rtl/wb_ddr_arbiter.sv | 159 +++++++++++++++
 tb/tb_wb_ddr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ddr_arbiter_pkg.sv
`default_nettype none
//============================================================================
// Module   : wb_ddr_arbiter_pkg
// Brief    : Shared FSM state type and round-robin pick helper for the
//            Wishbone-to-DDR arbiter.
// Revision : 1.0 - initial release
//============================================================================
package wb_ddr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    localparam int c_MAX_PORTS = 8;

    // First set bit of req at or after ptr, wrapping at nports.
    function automatic logic [2:0] f_rr_next(
        input logic [7:0] req,
        input logic [2:0] ptr,
        input int         nports
    );
        logic [2:0] res;
        logic [3:0] idx;
        logic       found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < c_MAX_PORTS; i++) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'(nports)) begin
                idx = idx - 4'(nports);
            end
            if (!found && (i < nports) && req[idx[2:0]]) begin
                res   = idx[2:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_picker.sv
`default_nettype none
//============================================================================
// Module   : wb_rr_picker
// Brief    : Combinational round-robin picker: request vector + pointer ->
//            one-hot grant and index.
// Revision : 1.0 - initial release
//============================================================================
module wb_rr_picker #(
    parameter int NPORTS = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NPORTS-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NPORTS-1:0] o_gnt_oh,
    output logic [IDX_W-1:0]  o_gnt_idx,
    output logic              o_valid
);
    import wb_ddr_arbiter_pkg::*;

    logic [7:0] w_req8;
    logic [2:0] w_ptr3;
    logic [2:0] w_idx3;

    always_comb begin
        w_req8              = '0;
        w_req8[NPORTS-1:0]  = i_req;
        w_ptr3              = '0;
        w_ptr3[IDX_W-1:0]   = i_ptr;
    end

    assign w_idx3    = f_rr_next(w_req8, w_ptr3, NPORTS);
    assign o_gnt_idx = w_idx3[IDX_W-1:0];
    assign o_valid   = |i_req;

    for (genvar k = 0; k < NPORTS; k++) begin : g_oh
        assign o_gnt_oh[k] = o_valid && (w_idx3 == 3'(k));
    end

endmodule
`default_nettype wire

// File: rtl/wb_ddr_arbiter.sv
`default_nettype none
//============================================================================
// Module   : wb_ddr_arbiter
// Brief    : N-port pipelined Wishbone arbiter in front of a DDR3 controller
//            with round-robin ownership and an outstanding-request limit.
// Revision : 1.0 - initial release
//============================================================================
module wb_ddr_arbiter #(
    parameter int NPORTS    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NPORTS-1:0]          i_s_cyc,
    input  logic [NPORTS-1:0]          i_s_stb,
    input  logic [NPORTS-1:0]          i_s_we,
    input  logic [NPORTS*ADDR_W-1:0]   i_s_addr,
    input  logic [NPORTS*DATA_W-1:0]   i_s_data,
    input  logic [NPORTS*DATA_W/8-1:0] i_s_sel,
    output logic [NPORTS-1:0]          o_s_stall,
    output logic [NPORTS-1:0]          o_s_ack,
    output logic [NPORTS-1:0]          o_s_err,
    output logic [DATA_W-1:0]          o_s_data,
    output logic                       o_m_cyc,
    output logic                       o_m_stb,
    output logic                       o_m_we,
    output logic [ADDR_W-1:0]          o_m_addr,
    output logic [DATA_W-1:0]          o_m_data,
    output logic [DATA_W/8-1:0]        o_m_sel,
    input  logic                       i_m_stall,
    input  logic                       i_m_ack,
    input  logic                       i_m_err,
    input  logic [DATA_W-1:0]          i_m_data,
    output logic [NPORTS-1:0]          o_grant
);
    import wb_ddr_arbiter_pkg::*;

    localparam int SEL_W   = DATA_W / 8;
    localparam int c_OWN_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int c_OUT_W = $clog2(MAX_OUTST + 1);

    state_t               r_state;
    logic [c_OWN_W-1:0]   r_owner;
    logic [c_OWN_W-1:0]   r_rr_ptr;
    logic [c_OUT_W-1:0]   r_outst;
    logic [NPORTS-1:0]    r_grant;

    logic [NPORTS-1:0]    w_pick_oh;
    logic [c_OWN_W-1:0]   w_pick_idx;
    logic                 w_pick_valid;

    logic                 w_own_cyc, w_own_stb, w_own_we;
    logic [ADDR_W-1:0]    w_own_addr;
    logic [DATA_W-1:0]    w_own_data;
    logic [SEL_W-1:0]     w_own_sel;
    logic [NPORTS-1:0]    w_own_oh;

    logic w_owned, w_full, w_accept, w_resp_ok, w_ack, w_err, w_other_cyc, w_yield;

    wb_rr_picker #(
        .NPORTS (NPORTS),
        .IDX_W  (c_OWN_W)
    ) u_picker (
        .i_req     (i_s_cyc),
        .i_ptr     (r_rr_ptr),
        .o_gnt_oh  (w_pick_oh),
        .o_gnt_idx (w_pick_idx),
        .o_valid   (w_pick_valid)
    );

    always_comb begin
        w_own_cyc  = 1'b0;
        w_own_stb  = 1'b0;
        w_own_we   = 1'b0;
        w_own_addr = '0;
        w_own_data = '0;
        w_own_sel  = '0;
        w_own_oh   = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (r_owner == c_OWN_W'(k)) begin
                w_own_cyc   = i_s_cyc[k];
                w_own_stb   = i_s_stb[k];
                w_own_we    = i_s_we[k];
                w_own_addr  = i_s_addr[k*ADDR_W +: ADDR_W];
                w_own_data  = i_s_data[k*DATA_W +: DATA_W];
                w_own_sel   = i_s_sel[k*SEL_W +: SEL_W];
                w_own_oh[k] = 1'b1;
            end
        end
    end

    assign w_owned = (r_state == ST_OWNED);
    assign w_full  = (r_outst == c_OUT_W'(MAX_OUTST));

    // Bus cycle falls with the owner's cyc, abandoning any in-flight responses.
    assign o_m_cyc  = w_owned && w_own_cyc;
    assign o_m_stb  = o_m_cyc && w_own_stb && !w_full;
    assign o_m_we   = w_own_we;
    assign o_m_addr = w_own_addr;
    assign o_m_data = w_own_data;
    assign o_m_sel  = w_own_sel;

    assign w_accept  = o_m_stb && !i_m_stall;
    assign w_resp_ok = o_m_cyc && (r_outst != '0);
    assign w_ack     = w_resp_ok && i_m_ack;
    assign w_err     = w_resp_ok && i_m_err;

    assign o_s_ack   = w_ack ? w_own_oh : '0;
    assign o_s_err   = w_err ? w_own_oh : '0;
    assign o_s_stall = w_owned ? (~w_own_oh | {NPORTS{i_m_stall || w_full}}) : '1;
    assign o_s_data  = i_m_data;
    assign o_grant   = r_grant;

    assign w_other_cyc = |(i_s_cyc & ~w_own_oh);
    assign w_yield     = (r_outst == '0) && !w_own_stb && w_other_cyc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_outst  <= '0;
            r_grant  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_outst <= '0;
                    if (w_pick_valid) begin
                        r_state  <= ST_OWNED;
                        r_owner  <= w_pick_idx;
                        r_grant  <= w_pick_oh;
                        r_rr_ptr <= (w_pick_idx == c_OWN_W'(NPORTS - 1)) ? '0
                                                                         : w_pick_idx + 1'b1;
                    end
                end
                ST_OWNED: begin
                    if (!w_own_cyc || w_yield) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_outst <= '0;
                    end else if (w_accept && !(w_ack || w_err)) begin
                        r_outst <= r_outst + 1'b1;
                    end else if (!w_accept && (w_ack || w_err)) begin
                        r_outst <= r_outst - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_outst <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_ddr_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_wb_ddr_arbiter
// Brief    : Directed self-checking bench for wb_ddr_arbiter with a response
//            scoreboard and a fixed-latency downstream model.
// Revision : 1.0 - initial release
//============================================================================
module tb_wb_ddr_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    s_cyc = '0;
    logic [NP-1:0]    s_stb = '0;
    logic [NP-1:0]    s_we  = '0;
    logic [NP*AW-1:0] s_addr = '0;
    logic [NP*DW-1:0] s_data = '0;
    logic [NP*SW-1:0] s_sel  = '1;
    logic [NP-1:0]    s_stall, s_ack, s_err, grant;
    logic [DW-1:0]    s_rdata;
    logic             m_cyc, m_stb, m_we;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_wdata;
    logic [SW-1:0]    m_sel;

    logic          m_stall  = 1'b0;
    logic          man_ack  = 1'b0;
    logic          man_err  = 1'b0;
    logic [DW-1:0] man_data = '0;
    logic          mdl_en   = 1'b0;
    logic          mdl_ack  = 1'b0;
    logic [DW-1:0] mdl_data = '0;
    logic          m_ack;
    logic [DW-1:0] m_rdata;

    assign m_ack   = man_ack | mdl_ack;
    assign m_rdata = mdl_ack ? mdl_data : man_data;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [71:0] exp_q[$];
    logic [71:0] mon_e;
    int          ack_cnt[NP];
    int          acc;
    int          base;

    wb_ddr_arbiter #(
        .NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s_cyc(s_cyc), .i_s_stb(s_stb), .i_s_we(s_we),
        .i_s_addr(s_addr), .i_s_data(s_data), .i_s_sel(s_sel),
        .o_s_stall(s_stall), .o_s_ack(s_ack), .o_s_err(s_err), .o_s_data(s_rdata),
        .o_m_cyc(m_cyc), .o_m_stb(m_stb), .o_m_we(m_we),
        .o_m_addr(m_addr), .o_m_data(m_wdata), .o_m_sel(m_sel),
        .i_m_stall(m_stall), .i_m_ack(m_ack), .i_m_err(man_err), .i_m_data(m_rdata),
        .o_grant(grant)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] resp_of(input logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream model: acks each accepted request three cycles later.
    logic        p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;
    logic [31:0] a0 = '0, a1 = '0, a2 = '0;
    always @(posedge clk) begin
        p2 = p1; a2 = a1;
        p1 = p0; a1 = a0;
        p0 = mdl_en && m_cyc && m_stb && !m_stall;
        a0 = m_addr;
        #1;
        mdl_ack  = p2;
        mdl_data = resp_of(a2);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < NP; p++) begin
                if (s_ack[p]) begin
                    ack_cnt[p]++;
                    chk("ack_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("ack_port", 64'(p), 64'(mon_e[71:64]));
                        chk("ack_data", s_rdata, mon_e[63:0]);
                    end
                end
            end
        end
    end

    task automatic issue(input int p, input logic [31:0] a, input bit push);
        int n;
        n = 0;
        s_stb[p] = 1'b1;
        s_we[p]  = 1'b0;
        s_addr[p*AW +: AW] = a;
        #1;
        while (s_stall[p] && n < 40) begin
            tick();
            #1;
            n++;
        end
        chk("issue_accept", 64'(s_stall[p]), 64'd0);
        if (push) exp_q.push_back({8'(p), resp_of(a)});
        tick();
        s_stb[p] = 1'b0;
    endtask

    initial begin
        // Reset state with requests pending
        s_cyc = 2'b11; s_stb = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_mcyc",  64'(m_cyc), 64'd0);
        chk("rst_mstb",  64'(m_stb), 64'd0);
        chk("rst_stall", 64'(s_stall), 64'h3);
        chk("rst_ack",   64'(s_ack), 64'd0);
        chk("rst_err",   64'(s_err), 64'd0);
        s_cyc = '0; s_stb = '0; rst_n = 1'b1;
        tick();

        // Four pipelined reads on port 0
        mdl_en = 1'b1;
        s_cyc[0] = 1'b1;
        for (int i = 0; i < 4; i++) issue(0, 32'h100 + 32'(i * 8), 1'b1);
        chk("own_grant", 64'(grant), 64'h1);
        repeat (6) tick();
        chk("four_acks", 64'(ack_cnt[0]), 64'd4);
        chk("q_drained", 64'(exp_q.size()), 64'd0);
        chk("outst_zero", 64'(dut.r_outst), 64'd0);
        s_cyc[0] = 1'b0;
        tick();
        chk("release_grant", 64'(grant), 64'd0);

        // Simultaneous requests from reset: port 0 first, then port 1
        rst_n = 1'b0; #1; rst_n = 1'b1;
        m_stall = 1'b1; s_cyc = 2'b11; s_stb = 2'b01;
        tick();
        chk("rr_first", 64'(grant), 64'h1);
        chk("rr_stall", 64'(s_stall), 64'h3);
        tick();
        chk("rr_hold", 64'(grant), 64'h1);
        s_cyc = 2'b10; s_stb = '0;
        tick();
        chk("rr_gap", 64'(grant), 64'd0);
        tick();
        chk("rr_second", 64'(grant), 64'h2);
        chk("rr_ptr", 64'(dut.r_rr_ptr), 64'd0);
        s_cyc = '0; m_stall = 1'b0;
        tick();

        // Outstanding limit
        mdl_en = 1'b0;
        s_cyc[0] = 1'b1; s_stb[0] = 1'b1; acc = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (!s_stall[0]) acc++;
            tick();
        end
        chk("accepted_max", 64'(acc), 64'd8);
        #1;
        chk("full_stall", 64'(s_stall[0]), 64'd1);
        chk("full_stb", 64'(m_stb), 64'd0);
        chk("full_outst", 64'(dut.r_outst), 64'd8);
        exp_q.push_back({8'd0, resp_of(32'hABC)});
        man_data = resp_of(32'hABC); man_ack = 1'b1;
        #1;
        chk("full_ack", 64'(s_ack), 64'h1);
        tick();
        man_ack = 1'b0;
        #1;
        chk("ninth_ready", 64'(s_stall[0]), 64'd0);
        chk("outst_seven", 64'(dut.r_outst), 64'd7);
        tick();
        #1;
        chk("ninth_taken", 64'(s_stall[0]), 64'd1);
        s_stb = '0; s_cyc = '0;
        tick();
        chk("drop_clears", 64'(dut.r_outst), 64'd0);

        // Owner drops cyc with three outstanding
        mdl_en = 1'b1;
        s_cyc[0] = 1'b1;
        for (int i = 0; i < 3; i++) issue(0, 32'h200 + 32'(i * 8), 1'b0);
        chk("outst_three", 64'(dut.r_outst), 64'd3);
        s_cyc[0] = 1'b0;
        #1;
        chk("drop_mcyc", 64'(m_cyc), 64'd0);
        base = ack_cnt[0];
        repeat (5) tick();
        chk("discarded_acks", 64'(ack_cnt[0] - base), 64'd0);
        chk("discard_outst", 64'(dut.r_outst), 64'd0);
        s_cyc[1] = 1'b1;
        issue(1, 32'h300, 1'b1);
        chk("p1_grant", 64'(grant), 64'h2);
        repeat (5) tick();
        chk("p1_ack", 64'(ack_cnt[1]), 64'd1);
        s_cyc = '0;
        tick();
        mdl_en = 1'b0;

        // Idle-yield
        s_cyc[0] = 1'b1;
        tick();
        chk("y_own0", 64'(grant), 64'h1);
        s_cyc[1] = 1'b1; s_stb[1] = 1'b1; m_stall = 1'b1;
        tick();
        chk("y_idle", 64'(grant), 64'd0);
        chk("y_idle_stall", 64'(s_stall), 64'h3);
        tick();
        chk("y_own1", 64'(grant), 64'h2);
        chk("y_p0_stall", 64'(s_stall[0]), 64'd1);
        tick();
        chk("y_own1_hold", 64'(grant), 64'h2);
        chk("y_p0_stall2", 64'(s_stall[0]), 64'd1);
        s_cyc[1] = 1'b0; s_stb[1] = 1'b0; m_stall = 1'b0;
        tick();
        tick();
        chk("y_regrant0", 64'(grant), 64'h1);
        chk("y_p0_go", 64'(s_stall[0]), 64'd0);

        // Accept+ack same cycle, error routing, stray ack
        issue(0, 32'h400, 1'b1);
        issue(0, 32'h408, 1'b1);
        chk("outst_two", 64'(dut.r_outst), 64'd2);
        s_stb[0] = 1'b1; s_addr[AW-1:0] = 32'h410;
        man_data = resp_of(32'h400); man_ack = 1'b1;
        #1;
        chk("acc_ack_ready", 64'(s_stall[0]), 64'd0);
        tick();
        man_ack = 1'b0; s_stb[0] = 1'b0;
        exp_q.push_back({8'd0, resp_of(32'h410)});
        chk("acc_ack_outst", 64'(dut.r_outst), 64'd2);
        man_err = 1'b1;
        #1;
        chk("err_route", 64'(s_err), 64'h1);
        chk("err_noack", 64'(s_ack), 64'd0);
        tick();
        man_err = 1'b0;
        void'(exp_q.pop_front());
        chk("err_outst", 64'(dut.r_outst), 64'd1);
        man_data = resp_of(32'h410); man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("outst_empty", 64'(dut.r_outst), 64'd0);
        man_ack = 1'b1;
        #1;
        chk("stray_ack", 64'(s_ack), 64'd0);
        tick();
        man_ack = 1'b0;
        chk("no_underflow", 64'(dut.r_outst), 64'd0);

        // Asynchronous reset mid-transaction
        issue(0, 32'h500, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mcyc", 64'(m_cyc), 64'd0);
        chk("arst_stall", 64'(s_stall), 64'h3);
        chk("arst_outst", 64'(dut.r_outst), 64'd0);
        s_cyc = '0;
        rst_n = 1'b1;
        tick();
        chk("final_q", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
